// File: rtl/sap_control_sequencer_pkg.sv
// sap_pkg: shared types and control-word constants for the SAP control sequencer.
// Optional build macro used by the sequencer: SAP_SKIP_NOP_EN (variable machine cycle).
package sap_pkg;

    // Opcodes carried in IR[7:4]; any other value decodes as a NOP.
    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // One-hot ring states, bit0 = T1.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    // Control word, MSB first, in datapath pin order.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } con_t;

    localparam logic [11:0] CW_IDLE     = 12'h3E3; // every load/enable inactive
    localparam logic [11:0] CW_FETCH_T1 = 12'h5E3; // PC -> MAR
    localparam logic [11:0] CW_FETCH_T2 = 12'hBE3; // PC increment
    localparam logic [11:0] CW_FETCH_T3 = 12'h263; // RAM -> IR
    localparam logic [11:0] CW_ADDR_T4  = 12'h1A3; // IR operand -> MAR
    localparam logic [11:0] CW_LDA_T5   = 12'h2C3; // RAM -> A
    localparam logic [11:0] CW_LDB_T5   = 12'h2E1; // RAM -> B
    localparam logic [11:0] CW_ADD_T6   = 12'h3C7; // A + B -> A
    localparam logic [11:0] CW_SUB_T6   = 12'h3CF; // A - B -> A
    localparam logic [11:0] CW_OUT_T4   = 12'h3F2; // A -> OUT

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Sequencer bus: run/opcode in from the controller side, control word and status out.
interface sap_control_sequencer_if;
    import sap_pkg::*;

    logic        run;
    logic [3:0]  opcode;
    con_t        con;
    logic [5:0]  tstate;
    logic        halted;

    // Drives run/opcode and observes the sequencer.
    modport master (output run, output opcode, input con, input tstate, input halted);
    // The sequencer itself.
    modport slave  (input run, input opcode, output con, output tstate, output halted);
endinterface

// File: rtl/sap_control_sequencer_ring.sv
// sap_ring_counter: one-hot T1..T6 ring with hold, advance and restart-to-T1.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       adv,
    input  logic       restart,
    output logic [5:0] tstate
);

    logic [5:0] tstate_reg;
    logic [5:0] tstate_next;

    // Rotate left by one: each bit takes the value of its predecessor, T6 wraps to T1.
    for (genvar gi = 0; gi < 6; gi++) begin : g_rot
        assign tstate_next[gi] = tstate_reg[(gi + 5) % 6];
    end

    // Ring register: restart wins over a plain advance; otherwise hold.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tstate_reg <= T1;
        end else if (restart) begin
            tstate_reg <= T1;
        end else if (adv) begin
            tstate_reg <= tstate_next;
        end
    end

    assign tstate = tstate_reg;

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: T-state ring plus opcode decode producing the 12-bit SAP control word.
// Optional build macro: SAP_SKIP_NOP_EN -- end an instruction right after its last non-idle step.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int T_STATES = 6
) (
    input  logic                   clk,
    input  logic                   clr_n,
    sap_control_sequencer_if.slave bus
);

    if (T_STATES != 6) begin : g_bad_tstates
        $error("sap_control_sequencer: only T_STATES=6 is supported");
    end
    if (OP_W != 4) begin : g_bad_opw
        $error("sap_control_sequencer: only OP_W=4 is supported");
    end

    opcode_e     op;
    logic [5:0]  tstate;
    logic        halted_reg;
    logic        adv;
    logic        restart;
    logic [11:0] con_word;

    assign op  = opcode_e'(bus.opcode);
    assign adv = bus.run & ~halted_reg;

`ifdef SAP_SKIP_NOP_EN
    // Cut the instruction short once nothing but idle words remain.
    always_comb begin
        restart = 1'b0;
        if (adv) begin
            if (tstate == T5 && op == OP_LDA) begin
                restart = 1'b1;
            end else if (tstate == T4 && op != OP_LDA && op != OP_ADD &&
                         op != OP_SUB && op != OP_HLT) begin
                restart = 1'b1;
            end
        end
    end
`else
    assign restart = 1'b0;
`endif

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr_n   (clr_n),
        .adv     (adv),
        .restart (restart),
        .tstate  (tstate)
    );

    // Halt latch: set at the edge that ends HLT's T4, cleared only by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            halted_reg <= 1'b0;
        end else if (adv && tstate == T4 && op == OP_HLT) begin
            halted_reg <= 1'b1;
        end
    end

    // Moore decode of (tstate, opcode, halted, run) into the control word.
    always_comb begin
        con_word = CW_IDLE;
        if (bus.run && !halted_reg) begin
            case (tstate)
                T1: con_word = CW_FETCH_T1;
                T2: con_word = CW_FETCH_T2;
                T3: con_word = CW_FETCH_T3;
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: con_word = CW_ADDR_T4;
                        OP_OUT:                 con_word = CW_OUT_T4;
                        default:                con_word = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA:         con_word = CW_LDA_T5;
                        OP_ADD, OP_SUB: con_word = CW_LDB_T5;
                        default:        con_word = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD:  con_word = CW_ADD_T6;
                        OP_SUB:  con_word = CW_SUB_T6;
                        default: con_word = CW_IDLE;
                    endcase
                end
                default: con_word = CW_IDLE;
            endcase
        end
    end

    assign bus.con    = con_t'(con_word);
    assign bus.tstate = tstate;
    assign bus.halted = halted_reg;

endmodule
